// File: rtl/regfile_pkg.sv
// Shared definitions for the dual-writeback register file: bypass priority,
// the hardwired-zero address and the packed read-port slice helper.
package regfile_pkg;

  typedef enum logic {
    PORT_B_FIRST = 1'b0,
    PORT_A_FIRST = 1'b1
  } bypass_prio_e;

  // Loads (port B) retire after ALU results (port A), so B holds the newer value.
  localparam bypass_prio_e BYPASS_PRIO = PORT_B_FIRST;
  localparam int unsigned  ZERO_ADDR   = 0;

  // LSB of port `port` within a packed bus of `width`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for outstanding loads, per-read-port busy lookup
// and a registered population count of the pending vector.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic                  sb_set_en,
  input  logic [ADDR_W-1:0]     sb_set_addr,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] pending_q, pending_d;
  logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;

  // Set is applied after clear so a back-to-back load keeps the bit pending.
  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < NREG; r++) begin
      if (wb_en && wb_addr == ADDR_W'(r))
        pending_d[r] = 1'b0;
      if (sb_set_en && sb_set_addr == ADDR_W'(r) &&
          !(ZERO_REG != 0 && r == int'(ZERO_ADDR)))
        pending_d[r] = 1'b1;
    end
  end

  // Count lags the pending bits by one cycle.
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++)
      busy_cnt_d = busy_cnt_d + (ADDR_W + 1)'(pending_q[r]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_busy
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
      assign rd_busy[gi] = pending_q[addr] &&
                           !(wb_en && wb_addr == addr) &&
                           !(ZERO_REG != 0 && addr == ADDR_W'(ZERO_ADDR));
    end
  endgenerate

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write register file with write-through bypass, hardwired
// zero register and a load scoreboard for ID-stage hazard detection.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  sb_set_en,
  input  logic [ADDR_W-1:0]     sb_set_addr,
  output logic                  wr_conflict,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_conflict_q, wr_conflict_d;
  logic              wa_ok, wb_ok;

  assign wa_ok = wa_en && !(ZERO_REG != 0 && wa_addr == ADDR_W'(ZERO_ADDR));
  assign wb_ok = wb_en && !(ZERO_REG != 0 && wb_addr == ADDR_W'(ZERO_ADDR));

  // The higher-priority port is written last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (BYPASS_PRIO == PORT_B_FIRST) begin
      if (wa_ok) regs_d[wa_addr] = wa_data;
      if (wb_ok) regs_d[wb_addr] = wb_data;
    end else begin
      if (wb_ok) regs_d[wb_addr] = wb_data;
      if (wa_ok) regs_d[wa_addr] = wa_data;
    end
  end

  assign wr_conflict_d = wa_ok && wb_ok && (wa_addr == wb_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];

      always_comb begin
        data = regs_q[addr];
        if (BYPASS != 0) begin
          if (BYPASS_PRIO == PORT_B_FIRST) begin
            if (wa_en && wa_addr == addr) data = wa_data;
            if (wb_en && wb_addr == addr) data = wb_data;
          end else begin
            if (wb_en && wb_addr == addr) data = wb_data;
            if (wa_en && wa_addr == addr) data = wa_data;
          end
        end
        if (ZERO_REG != 0 && addr == ADDR_W'(ZERO_ADDR))
          data = '0;
      end

      assign rd_data[port_lsb(gi, DATA_W) +: DATA_W] = data;
    end
  endgenerate

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .busy_cnt    (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_mp_sb;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en, wb_en, sb_set_en;
  logic [4:0]  wa_addr, wb_addr, sb_set_addr;
  logic [31:0] wa_data, wb_data;
  logic        wr_conflict;
  logic [5:0]  busy_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state: architectural registers, pending set, registered outputs.
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_pend;
  int          mdl_cnt;
  logic        mdl_conf;

  regfile_mp_sb dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wa_en       (wa_en),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .wr_conflict (wr_conflict),
    .busy_cnt    (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mdl_regs[r] = '0;
    mdl_pend = '0;
    mdl_cnt  = 0;
    mdl_conf = 1'b0;
  endtask

  task automatic idle_inputs();
    wa_en = 0; wb_en = 0; sb_set_en = 0;
    wa_addr = 0; wb_addr = 0; sb_set_addr = 0;
    wa_data = 0; wb_data = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return mdl_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return (a != 0) && mdl_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  // Advance one clock: compute the architectural effect of the current inputs,
  // then commit it just after the edge.
  task automatic tick();
    logic [31:0] nregs [32];
    logic [31:0] npend;
    int          ncnt;
    logic        nconf;
    nregs = mdl_regs;
    npend = mdl_pend;
    ncnt  = $countones(mdl_pend);
    nconf = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
    if (wa_en && wa_addr != 0) nregs[wa_addr] = wa_data;
    if (wb_en && wb_addr != 0) nregs[wb_addr] = wb_data;
    if (wb_en) npend[wb_addr] = 1'b0;
    if (sb_set_en && sb_set_addr != 0) npend[sb_set_addr] = 1'b1;
    @(posedge clk);
    #1;
    mdl_regs = nregs;
    mdl_pend = npend;
    mdl_cnt  = ncnt;
    mdl_conf = nconf;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 16; a++) begin
      rd_addr = {5'(a * 2 + 1), 5'(a * 2)};
      #3;
      checks++;
      if (rd_data !== 64'h0) begin
        failures++;
        $display("FAIL reset_rd_data addr=%0d: got %h expected 0", a * 2, rd_data);
      end
      checks++;
      if (rd_busy !== 2'b00 || busy_cnt !== 6'd0 || wr_conflict !== 1'b0) begin
        failures++;
        $display("FAIL reset_status addr=%0d: busy=%b cnt=%0d conf=%b expected 0", a * 2, rd_busy, busy_cnt, wr_conflict);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
    rd_addr = {5'd6, 5'd5};
    #3;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[31:0]);
    end
    tick();
    idle_inputs();
    #3;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[31:0] !== exp_rd(5)) begin
      failures++;
      $display("FAIL bypass_stored: got %h expected deadbeef", rd_data[31:0]);
    end
    tick();
  endtask

  task automatic test_conflict();
    wa_en = 1; wa_addr = 7; wa_data = 32'h11;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22;
    rd_addr = {5'd0, 5'd7};
    #3;
    checks++;
    if (rd_data[31:0] !== 32'h22 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_bypass: data=%h conf=%b expected 22/0", rd_data[31:0], wr_conflict);
    end
    tick();
    idle_inputs();
    #3;
    checks++;
    if (rd_data[31:0] !== 32'h22 || wr_conflict !== 1'b1) begin
      failures++;
      $display("FAIL conflict_pulse: data=%h conf=%b expected 22/1", rd_data[31:0], wr_conflict);
    end
    tick();
    #3;
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL conflict_one_cycle: conf=%b expected 0", wr_conflict);
    end
    wa_en = 1; wa_addr = 0; wa_data = 32'h11;
    wb_en = 1; wb_addr = 0; wb_data = 32'h22;
    rd_addr = {5'd0, 5'd0};
    #0;
    checks++;
    if (rd_data !== 64'h0) begin
      failures++;
      $display("FAIL zero_bypass: got %h expected 0", rd_data);
    end
    tick();
    idle_inputs();
    #3;
    checks++;
    if (rd_data !== 64'h0 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_conflict: data=%h conf=%b expected 0/0", rd_data, wr_conflict);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    sb_set_en = 1; sb_set_addr = 9;
    rd_addr = {5'd0, 5'd9};
    #3;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL sb_no_same_cycle_set: busy=%b expected 0", rd_busy[0]);
    end
    tick();
    idle_inputs();
    #3;
    checks++;
    if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'(mdl_cnt)) begin
      failures++;
      $display("FAIL sb_set: busy=%b cnt=%0d expected 1/%0d", rd_busy[0], busy_cnt, mdl_cnt);
    end
    tick();
    checks++;
    if (busy_cnt !== 6'd1) begin
      failures++;
      $display("FAIL sb_cnt_one: cnt=%0d expected 1", busy_cnt);
    end
    wb_en = 1; wb_addr = 9; wb_data = 32'h33;
    #3;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h33) begin
      failures++;
      $display("FAIL sb_clear_unblock: busy=%b data=%h expected 0/33", rd_busy[0], rd_data[31:0]);
    end
    tick();
    idle_inputs();
    tick();
    checks++;
    if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h33) begin
      failures++;
      $display("FAIL sb_cnt_zero: cnt=%0d busy=%b data=%h expected 0/0/33", busy_cnt, rd_busy[0], rd_data[31:0]);
    end
  endtask

  task automatic test_set_clear();
    sb_set_en = 1; sb_set_addr = 9;
    wb_en = 1; wb_addr = 9; wb_data = 32'h44;
    rd_addr = {5'd9, 5'd9};
    tick();
    idle_inputs();
    #3;
    checks++;
    if (rd_data[31:0] !== 32'h44 || rd_busy !== 2'b11) begin
      failures++;
      $display("FAIL set_wins: data=%h busy=%b expected 44/11", rd_data[31:0], rd_busy);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) begin
      wa_en = 1'($urandom_range(0, 1));
      wb_en = 1'($urandom_range(0, 1));
      sb_set_en = 1'($urandom_range(0, 1));
      wa_addr = 5'($urandom_range(0, 7));
      wb_addr = 5'($urandom_range(0, 7));
      sb_set_addr = 5'($urandom_range(0, 7));
      wa_data = $urandom;
      wb_data = $urandom;
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      #3;
      for (int p = 0; p < 2; p++) begin
        logic [4:0] a;
        a = rd_addr[p * 5 +: 5];
        checks++;
        if (rd_data[p * 32 +: 32] !== exp_rd(a) || rd_busy[p] !== exp_busy(a)) begin
          failures++;
          $display("FAIL rand_read cyc=%0d port=%0d addr=%0d: data=%h busy=%b expected %h/%b",
                   c, p, a, rd_data[p * 32 +: 32], rd_busy[p], exp_rd(a), exp_busy(a));
        end
      end
      checks++;
      if (wr_conflict !== mdl_conf || busy_cnt !== 6'(mdl_cnt)) begin
        failures++;
        $display("FAIL rand_status cyc=%0d: conf=%b cnt=%0d expected %b/%0d", c, wr_conflict, busy_cnt, mdl_conf, mdl_cnt);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    sb_set_en = 1; sb_set_addr = 1;
    tick();
    sb_set_addr = 2;
    tick();
    sb_set_addr = 3;
    wa_en = 1; wa_addr = 4; wa_data = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    rd_addr = {5'd1, 5'd4};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hCAFE_F00D || rd_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state: data=%h busy=%b expected cafef00d/1", rd_data[31:0], rd_busy[1]);
    end
    #1;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0 || wr_conflict !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: data=%h busy=%b cnt=%0d conf=%b expected all 0", rd_data, rd_busy, busy_cnt, wr_conflict);
    end
    rd_addr = {5'd3, 5'd2};
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      failures++;
      $display("FAIL async_reset_pending: busy=%b expected 00", rd_busy);
    end
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 1;
    rd_addr = '0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    test_reset();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_set_clear();
    test_random(300);
    test_async_reset();
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
